// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB master bridge.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/apb_master_bridge_timeout_cnt.sv
// Saturating ACCESS wait counter; flags the cycle on which the wait limit is reached.
module apb_timeout_cnt
  import apb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] SAT  = (TIMEOUT_CYCLES == 0) ? {CW{1'b1}} : CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != SAT)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Expired means this wait cycle is the one that brings the count to the limit.
  assign o_expired = (TIMEOUT_CYCLES != 0) && i_enable && (r_cnt >= LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-request APB master: request/response handshakes on one side, APB SETUP/ACCESS on the other.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1; valid, once raised, holds its payload stable until that edge.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      REQ_VALID,
  output logic                      REQ_READY,
  input  logic [APB_ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic                      REQ_WRITE,
  input  logic [31:0]               REQ_WDATA,
  output logic                      RSP_VALID,
  input  logic                      RSP_READY,
  output logic [31:0]               RSP_RDATA,
  output logic                      RSP_ERR,
  output logic                      RSP_TIMEOUT,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  output apb_state_e                o_dbg_state
);

  apb_state_e                r_state;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [31:0]               r_pwdata;
  logic                      r_pwrite;
  logic                      r_psel;
  logic                      r_penable;
  logic                      r_rsp_valid;
  logic [31:0]               r_rsp_rdata;
  logic                      r_rsp_err;
  logic                      r_rsp_timeout;
  logic                      w_cnt_clear;
  logic                      w_cnt_enable;
  logic                      w_expired;

  assign w_cnt_clear  = (r_state == SETUP);
  assign w_cnt_enable = (r_state == ACCESS) && !PREADY;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .i_clear  (w_cnt_clear),
    .i_enable (w_cnt_enable),
    .o_expired(w_expired)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state       <= IDLE;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pwrite      <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (REQ_VALID) begin
            r_paddr   <= REQ_ADDR;
            r_pwrite  <= REQ_WRITE;
            r_pwdata  <= REQ_WDATA;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          // A slave completing on the limit cycle takes priority over the timeout.
          if (PREADY) begin
            r_rsp_rdata   <= r_pwrite ? 32'h0 : PRDATA;
            r_rsp_err     <= PSLVERR;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= RESP;
          end else if (w_expired) begin
            r_rsp_rdata   <= 32'h0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= RESP;
          end
        end
        RESP: begin
          if (RSP_READY) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  assign REQ_READY   = (r_state == IDLE);
  assign RSP_VALID   = r_rsp_valid;
  assign RSP_RDATA   = r_rsp_rdata;
  assign RSP_ERR     = r_rsp_err;
  assign RSP_TIMEOUT = r_rsp_timeout;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign PWRITE      = r_pwrite;
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: vector table of APB transactions plus reset corner sequences.
module tb_apb_master_bridge;
  import apb_master_pkg::*;

  localparam int AW     = 32;
  localparam int TO_CYC = 4;
  localparam int NEVER  = 99;

  logic          CLK;
  logic          RSTN;
  logic          REQ_VALID;
  logic          REQ_READY;
  logic [AW-1:0] REQ_ADDR;
  logic          REQ_WRITE;
  logic [31:0]   REQ_WDATA;
  logic          RSP_VALID;
  logic          RSP_READY;
  logic [31:0]   RSP_RDATA;
  logic          RSP_ERR;
  logic          RSP_TIMEOUT;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  apb_state_e    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [33:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    int          n_wait;
    logic [31:0] prdata;
    logic        pslverr;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  vec_t vecs[8];

  apb_master_bridge #(
    .APB_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .REQ_ADDR   (REQ_ADDR),
    .REQ_WRITE  (REQ_WRITE),
    .REQ_WDATA  (REQ_WDATA),
    .RSP_VALID  (RSP_VALID),
    .RSP_READY  (RSP_READY),
    .RSP_RDATA  (RSP_RDATA),
    .RSP_ERR    (RSP_ERR),
    .RSP_TIMEOUT(RSP_TIMEOUT),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PWRITE     (PWRITE),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR),
    .o_dbg_state(dbg_state)
  );

  // Clock and reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one request, plays the slave with n_wait wait states, then consumes the response.
  task automatic run_vec(input vec_t v);
    logic [33:0] exp_rsp;
    int n_acc;
    exp_q.push_back({v.exp_to, v.exp_err, v.exp_rdata});
    check("req_ready_idle", REQ_READY, 1);
    REQ_VALID = 1'b1;
    REQ_ADDR  = v.addr;
    REQ_WRITE = v.write;
    REQ_WDATA = v.wdata;
    tick();
    REQ_VALID = 1'b0;
    REQ_ADDR  = 32'hFFFF_FFFF;
    REQ_WRITE = ~v.write;
    REQ_WDATA = 32'h0BAD_0BAD;
    check("setup_psel", PSEL, 1);
    check("setup_penable", PENABLE, 0);
    check("setup_req_ready", REQ_READY, 0);
    check("setup_paddr", PADDR, v.addr);
    check("setup_pwrite", PWRITE, v.write);
    check("setup_pwdata", PWDATA, v.wdata);
    n_acc = (v.n_wait >= TO_CYC) ? TO_CYC : v.n_wait + 1;
    for (int k = 0; k < n_acc; k++) begin
      tick();
      check("access_psel", PSEL, 1);
      check("access_penable", PENABLE, 1);
      check("access_paddr", PADDR, v.addr);
      check("access_pwrite", PWRITE, v.write);
      check("access_pwdata", PWDATA, v.wdata);
      check("access_rsp_valid", RSP_VALID, 0);
      if (k == v.n_wait) begin
        PREADY  = 1'b1;
        PRDATA  = v.prdata;
        PSLVERR = v.pslverr;
      end else begin
        PREADY  = 1'b0;
        PRDATA  = 32'hBAD0_0000 | 32'(k);
        PSLVERR = 1'b1;
      end
    end
    tick();
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = $urandom;
    exp_rsp = exp_q.pop_front();
    check("rsp_valid", RSP_VALID, 1);
    check("rsp_psel_drop", PSEL, 0);
    check("rsp_penable_drop", PENABLE, 0);
    check("rsp_payload", {RSP_TIMEOUT, RSP_ERR, RSP_RDATA}, exp_rsp);
    for (int h = 0; h < v.hold; h++) begin
      tick();
      check("hold_rsp_valid", RSP_VALID, 1);
      check("hold_rsp_payload", {RSP_TIMEOUT, RSP_ERR, RSP_RDATA}, exp_rsp);
      check("hold_req_ready", REQ_READY, 0);
      check("hold_psel", PSEL, 0);
      check("hold_penable", PENABLE, 0);
    end
    check("resp_req_ready", REQ_READY, 0);
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    check("post_rsp_valid", RSP_VALID, 0);
    check("post_req_ready", REQ_READY, 1);
    check("post_psel", PSEL, 0);
  endtask

  initial begin
    // addr, write, wdata, n_wait, prdata, pslverr, hold, exp_rdata, exp_err, exp_to
    vecs[0] = '{32'h1A10_0004, 1'b1, 32'hDEAD_BEEF, 0,     32'h1234_5678, 1'b0, 0, 32'h0,         1'b0, 1'b0};
    vecs[1] = '{32'h1A10_0008, 1'b0, 32'h0,         3,     32'h3F80_0000, 1'b0, 0, 32'h3F80_0000, 1'b0, 1'b0};
    vecs[2] = '{32'h1A10_000C, 1'b0, 32'h0,         1,     32'hCAFE_F00D, 1'b1, 0, 32'hCAFE_F00D, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0020, 1'b0, 32'h0,         NEVER, 32'h7777_7777, 1'b0, 0, 32'h0,         1'b1, 1'b1};
    vecs[4] = '{32'h0000_0024, 1'b1, 32'hA5A5_5A5A, NEVER, 32'h6666_6666, 1'b0, 1, 32'h0,         1'b1, 1'b1};
    vecs[5] = '{32'h0000_0028, 1'b0, 32'h0,         TO_CYC - 1, 32'h55AA_55AA, 1'b0, 0, 32'h55AA_55AA, 1'b0, 1'b0};
    vecs[6] = '{32'hF000_0100, 1'b0, 32'h0,         2,     32'h0102_0304, 1'b0, 5, 32'h0102_0304, 1'b0, 1'b0};
    vecs[7] = '{32'hF000_0104, 1'b1, 32'h1111_2222, 0,     32'h9999_9999, 1'b1, 0, 32'h0,         1'b1, 1'b0};

    RSTN      = 1'b0;
    REQ_VALID = 1'b0;
    REQ_ADDR  = '0;
    REQ_WRITE = 1'b0;
    REQ_WDATA = '0;
    RSP_READY = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    tick();
    tick();
    check("rst_state", dbg_state, IDLE);
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rsp_valid", RSP_VALID, 0);
    check("rst_rsp_payload", {RSP_TIMEOUT, RSP_ERR, RSP_RDATA}, 0);
    check("rst_req_ready", REQ_READY, 1);
    RSTN = 1'b1;

    // First request is offered in the same cycle reset releases.
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
    end

    // Reset pulse in the middle of an ACCESS wait.
    REQ_VALID = 1'b1;
    REQ_ADDR  = 32'h1A10_0010;
    REQ_WRITE = 1'b0;
    tick();
    REQ_VALID = 1'b0;
    tick();
    check("abort_in_access", dbg_state, ACCESS);
    #2;
    RSTN = 1'b0;
    #1;
    check("abort_psel", PSEL, 0);
    check("abort_penable", PENABLE, 0);
    check("abort_paddr", PADDR, 0);
    check("abort_state", dbg_state, IDLE);
    tick();
    PREADY = 1'b1;
    PRDATA = 32'hDEAD_0001;
    #2;
    RSTN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("abort_no_rsp", RSP_VALID, 0);
      check("abort_no_psel", PSEL, 0);
    end
    PREADY = 1'b0;
    run_vec(vecs[1]);
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
